// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD line arbiter: line width, default row text,
// state encoding and the round-robin pick helper.
package lcd_pkg;

  localparam int unsigned LINE_W = 128;

  localparam logic [LINE_W-1:0] INIT_A_DEF = "Press BTN3 to   ";
  localparam logic [LINE_W-1:0] INIT_B_DEF = "show a message..";

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DWELL = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } grant_t;

  // Returns the winning requester index; on contention the one not granted last wins.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last_id);
    logic win;
    if (r0 && r1) begin
      win = ~last_id;
    end else begin
      win = r1;
    end
    return win;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Hold-off counter for the line arbiter: loads 1 on a grant, counts up while
// enabled and saturates at DWELL, where done is raised.
module dwell_timer #(
  parameter int unsigned DWELL = 70000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic count,
  output logic done
);

  localparam int unsigned CNT_W = (DWELL < 1) ? 1 : $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] DWELL_C = CNT_W'(DWELL);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

  logic [CNT_W-1:0] cnt_r;
  logic             done_s;

  // Terminal compare; the counter stops here so it can never wrap.
  always_comb begin
    done_s = 1'b0;
    if (cnt_r == DWELL_C) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
  end

  // Counter register: clear beats load, load beats counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= ZERO_C;
    end else if (clear) begin
      cnt_r <= ZERO_C;
    end else if (load) begin
      cnt_r <= ONE_C;
    end else if (count && !done_s) begin
      cnt_r <= cnt_r + ONE_C;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = done_s;

endmodule

// File: rtl/lcd_line_arbiter.sv
// Two-requester round-robin arbiter that scrolls accepted text lines into the
// two LCD rows and holds each new line for DWELL cycles before the next one.
module lcd_line_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned       DWELL  = 70000000,
  parameter logic [LINE_W-1:0] INIT_A = INIT_A_DEF,
  parameter logic [LINE_W-1:0] INIT_B = INIT_B_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [LINE_W-1:0] line0,
  input  logic              req1,
  input  logic [LINE_W-1:0] line1,
  input  logic              dir,
  input  logic              clear,
  output logic              ack0,
  output logic              ack1,
  output logic [LINE_W-1:0] row_A,
  output logic [LINE_W-1:0] row_B,
  output logic              update,
  output logic              busy
);

  logic [0:0]        state_r;
  logic              last_r;
  logic              ack0_r;
  logic              ack1_r;
  logic              update_r;
  logic [LINE_W-1:0] row_a_r;
  logic [LINE_W-1:0] row_b_r;

  grant_t            grant_s;
  logic [LINE_W-1:0] gline_s;
  logic              tmr_done_s;
  logic              tmr_count_s;

  // Grant decode: only in IDLE, never on a clear edge.
  always_comb begin
    grant_s = '{valid: 1'b0, id: 1'b0};
    gline_s = line0;
    if (!clear && (state_r == ST_IDLE) && (req0 || req1)) begin
      grant_s.valid = 1'b1;
      grant_s.id    = rr_pick(req0, req1, last_r);
    end else begin
      grant_s.valid = 1'b0;
      grant_s.id    = 1'b0;
    end
    if (grant_s.id) begin
      gline_s = line1;
    end else begin
      gline_s = line0;
    end
  end

  assign tmr_count_s = (state_r == ST_DWELL);

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .load  (grant_s.valid),
    .count (tmr_count_s),
    .done  (tmr_done_s)
  );

  // Control state, last-grant pointer and the one-cycle accept pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      last_r   <= 1'b1;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      update_r <= 1'b0;
    end else if (clear) begin
      state_r  <= ST_IDLE;
      last_r   <= last_r;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      update_r <= 1'b0;
    end else begin
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      update_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_s.valid) begin
            state_r  <= ST_DWELL;
            last_r   <= grant_s.id;
            ack0_r   <= ~grant_s.id;
            ack1_r   <= grant_s.id;
            update_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DWELL: begin
          if (tmr_done_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DWELL;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Row registers: scroll on a grant, restore the initial text on clear/reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_a_r <= INIT_A;
      row_b_r <= INIT_B;
    end else if (clear) begin
      row_a_r <= INIT_A;
      row_b_r <= INIT_B;
    end else if (grant_s.valid) begin
      if (dir) begin
        row_b_r <= row_a_r;
        row_a_r <= gline_s;
      end else begin
        row_a_r <= row_b_r;
        row_b_r <= gline_s;
      end
    end else begin
      row_a_r <= row_a_r;
      row_b_r <= row_b_r;
    end
  end

  assign ack0   = ack0_r;
  assign ack1   = ack1_r;
  assign update = update_r;
  assign row_A  = row_a_r;
  assign row_B  = row_b_r;
  assign busy   = (state_r == ST_DWELL);

endmodule

// File: tb/tb_lcd_line_arbiter.sv
// Self-checking bench for lcd_line_arbiter with DWELL=4: per-cycle comparison
// against a behavioural model plus directed literal expectations.
module tb_lcd_line_arbiter;

  localparam int DW = 4;
  localparam logic [127:0] IA  = "Press BTN3 to   ";
  localparam logic [127:0] IB  = "show a message..";
  localparam logic [127:0] L01 = "Fibo #01 is 0000";
  localparam logic [127:0] L19 = "Fibo #19 is 0FF1";
  localparam logic [127:0] LX0 = "AAAA line zero  ";
  localparam logic [127:0] LX1 = "BBBB line one   ";

  logic         clk = 1'b0;
  logic         reset, req0, req1, dir, clear;
  logic [127:0] line0, line1;
  logic         ack0, ack1, update, busy;
  logic [127:0] row_A, row_B;

  always #5 clk = ~clk;

  lcd_line_arbiter #(.DWELL(DW)) dut (
    .clk(clk), .reset(reset), .req0(req0), .line0(line0), .req1(req1),
    .line1(line1), .dir(dir), .clear(clear), .ack0(ack0), .ack1(ack1),
    .row_A(row_A), .row_B(row_B), .update(update), .busy(busy)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Behavioural model: a grant is possible only when no hold-off remains.
  logic [127:0] m_a, m_b;
  logic m_ack0, m_ack1, m_last;
  int   m_wait;
  logic m_win;
  assign m_win = (req0 && req1) ? ~m_last : req1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_a <= IA; m_b <= IB; m_ack0 <= 1'b0; m_ack1 <= 1'b0; m_last <= 1'b1; m_wait <= 0;
    end else if (clear) begin
      m_a <= IA; m_b <= IB; m_ack0 <= 1'b0; m_ack1 <= 1'b0; m_wait <= 0;
    end else if (m_wait == 0 && (req0 || req1)) begin
      m_ack0 <= ~m_win; m_ack1 <= m_win; m_last <= m_win; m_wait <= DW;
      if (dir) begin m_b <= m_a; m_a <= m_win ? line1 : line0; end
      else begin m_a <= m_b; m_b <= m_win ? line1 : line0; end
    end else begin
      m_ack0 <= 1'b0; m_ack1 <= 1'b0;
      if (m_wait > 0) m_wait <= m_wait - 1;
    end
  end

  // Observation log: cycle number, cumulative pulse/busy counts, grant list.
  int cyc = 0;
  int n_ack0 = 0, n_busy = 0;
  int g_id[$];
  int g_cyc[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (busy === 1'b1) n_busy++;
    if (ack0 === 1'b1) begin n_ack0++; g_id.push_back(0); g_cyc.push_back(cyc); end
    if (ack1 === 1'b1) begin g_id.push_back(1); g_cyc.push_back(cyc); end
  end

  task automatic cmp_all();
    chk("m_ack0", ack0, m_ack0);
    chk("m_ack1", ack1, m_ack1);
    chk("m_update", update, m_ack0 | m_ack1);
    chk("m_busy", busy, m_wait != 0);
    chk("m_row_A", row_A, m_a);
    chk("m_row_B", row_B, m_b);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    chk("idle_reached", busy, 1'b0);
    @(posedge clk); #2;
  endtask

  int b_ack0, b_busy, b_g;
  logic found;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; dir = 1'b0; clear = 1'b0;
    line0 = '0; line1 = '0;
    fork
      forever begin
        @(negedge clk);
        if (cmp_en) cmp_all();
      end
    join_none
    @(posedge clk); #2 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_row_A", row_A, IA);
    chk("rst_row_B", row_B, IB);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #2 reset = 1'b0;

    // Single req0, scroll up
    b_ack0 = n_ack0; b_busy = n_busy;
    line0 = L01; dir = 1'b0; req0 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (ack0 === 1'b1) found = 1'b1;
    end
    chk("a_ack0_seen", found, 1'b1);
    chk("a_row_A", row_A, IB);
    chk("a_row_B", row_B, L01);
    @(posedge clk); #2 req0 = 1'b0;
    repeat (8) @(posedge clk); #2;
    chk("a_one_ack0", 128'(n_ack0 - b_ack0), 128'(1));
    chk("a_busy_cycles", 128'(n_busy - b_busy), 128'(DW));

    // Clear, then req1 with scroll down
    clear = 1'b1; @(posedge clk); #2 clear = 1'b0;
    line1 = L19; dir = 1'b1; req1 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (ack1 === 1'b1) found = 1'b1;
    end
    chk("c_ack1_seen", found, 1'b1);
    chk("c_row_A", row_A, L19);
    chk("c_row_B", row_B, IA);
    @(posedge clk); #2 req1 = 1'b0;
    wait_idle();

    // Both held: alternate 0,1,0 spaced DWELL+1
    b_g = g_id.size();
    dir = 1'b0; line0 = LX0; line1 = LX1; req0 = 1'b1; req1 = 1'b1;
    repeat (13) @(negedge clk);
    @(posedge clk); #2 req0 = 1'b0; req1 = 1'b0;
    chk("b_three_grants", 128'(g_id.size() >= b_g + 3), 128'(1));
    if (g_id.size() >= b_g + 3) begin
      chk("b_g0_id", 128'(g_id[b_g]), 128'(0));
      chk("b_g1_id", 128'(g_id[b_g+1]), 128'(1));
      chk("b_g2_id", 128'(g_id[b_g+2]), 128'(0));
      chk("b_gap1", 128'(g_cyc[b_g+1] - g_cyc[b_g]), 128'(DW + 1));
      chk("b_gap2", 128'(g_cyc[b_g+2] - g_cyc[b_g+1]), 128'(DW + 1));
    end
    wait_idle();

    // Clear together with req0
    line0 = L01; dir = 1'b0; clear = 1'b1; req0 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("d_no_ack0", ack0, 1'b0);
    chk("d_row_A", row_A, IA);
    chk("d_row_B", row_B, IB);
    @(posedge clk); #2 clear = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("d_ack0_after_clear", ack0, 1'b1);
    @(posedge clk); #2 req0 = 1'b0;
    wait_idle();

    // Reset two cycles into DWELL, then req1 granted on first edge
    line0 = LX0; req0 = 1'b1;
    @(posedge clk); #2 req0 = 1'b0;
    @(posedge clk); @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("e_busy_rst", busy, 1'b0);
    chk("e_row_A_rst", row_A, IA);
    chk("e_row_B_rst", row_B, IB);
    @(posedge clk); #2 reset = 1'b0; dir = 1'b0; line1 = L19; req1 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("e_ack1_first", ack1, 1'b1);
    chk("e_row_A", row_A, IB);
    chk("e_row_B", row_B, L19);
    @(posedge clk); #2 req1 = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);
    #2 cmp_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lcd_line_arbiter.md
LCD_LINE_ARBITER -- requirements
Module: lcd_line_arbiter

Interface
REQ-001 Parameter DWELL, default 70000000, minimum cycles a freshly written line is held before the next update (legal range 1..2^27-1).
REQ-002 Parameter INIT_A, default "Press BTN3 to   ", 128-bit ASCII text of row_A after reset/clear.
REQ-003 Parameter INIT_B, default "show a message..", 128-bit ASCII text of row_B after reset/clear.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req0  input  1  requester 0 wants to push line0; held high until ack0.
REQ-007 line0  input  128  requester 0 text, 16 ASCII chars, MSB byte = leftmost char; stable while req0 high.
REQ-008 req1  input  1  requester 1 request, same rules as req0.
REQ-009 line1  input  128  requester 1 text, same format as line0.
REQ-010 dir  input  1  0 = scroll up, 1 = scroll down; sampled at grant.
REQ-011 clear  input  1  synchronous restore of initial text.
REQ-012 ack0  output  1  one-cycle pulse: line0 accepted.
REQ-013 ack1  output  1  one-cycle pulse: line1 accepted.
REQ-014 row_A  output  128  top LCD row text, registered, drives LCD_module row_A.
REQ-015 row_B  output  128  bottom LCD row text, registered, drives LCD_module row_B.
REQ-016 update  output  1  one-cycle pulse coincident with any row change from a grant.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 State machine SHALL have exactly two states: IDLE and DWELL.
REQ-019 In IDLE with req0|req1 sampled high at edge t, the block SHALL at edge t update rows, assert the granted ack and update for the following cycle, load the dwell counter with 1 and enter DWELL.
REQ-020 Scroll up (dir=0) SHALL perform row_A<=row_B, row_B<=granted line; scroll down (dir=1) SHALL perform row_B<=row_A, row_A<=granted line.
REQ-021 Arbitration SHALL be round-robin: a single requester wins; with both high, the requester not granted last wins; the last-grant pointer updates on each grant only.
REQ-022 In DWELL the counter SHALL increment once per cycle; when counter==DWELL the next state SHALL be IDLE; requests in DWELL SHALL be ignored (no ack).
REQ-023 Consecutive grants SHALL therefore be separated by exactly DWELL+1 cycles when a request is continuously pending.
REQ-024 ack0 and ack1 SHALL never be high in the same cycle; update SHALL equal ack0|ack1.
REQ-025 clear high at an edge SHALL load row_A=INIT_A, row_B=INIT_B, force IDLE, zero the counter, suppress any grant that edge, and leave the last-grant pointer unchanged.
REQ-026 clear SHALL have priority over a simultaneous request; a request still held after clear drops SHALL be granted on the next IDLE edge.
REQ-027 Counter width SHALL be $clog2(DWELL+1) bits; it SHALL never wrap.
REQ-028 Row outputs SHALL change only on grant, clear or reset.

Reset
REQ-029 reset asserted SHALL immediately force IDLE, counter 0, row_A=INIT_A, row_B=INIT_B, ack0=ack1=update=busy=0, last-grant pointer=1 (req0 wins first contention).
REQ-030 reset mid-DWELL SHALL abandon the dwell; first grant after release SHALL occur on the first edge with a request.

Structure
REQ-031 Shared package lcd_pkg SHALL hold LINE_W=128, the default INIT_A/INIT_B strings and the IDLE/DWELL state encoding.
REQ-032 The dwell counter SHALL be a sub-module dwell_timer (load, count, done at DWELL); arbitration and row shifting stay in the top module.

Verification
REQ-033 DWELL=4, req0 high with line0="Fibo #01 is 0000", dir=0 -> one ack0 pulse, row_A="show a message..", row_B=line0, busy high 4 cycles.
REQ-034 DWELL=4, req0 and req1 held high -> grants alternate ack0, ack1, ack0 at cycles t, t+5, t+10.
REQ-035 dir=1, req1 line1="Fibo #19 is 0FF1" -> row_A=line1, row_B="Press BTN3 to   ".
REQ-036 clear asserted same cycle as req0 in IDLE -> no ack0, rows equal INIT_A/INIT_B; ack0 on next cycle after clear deasserts.
REQ-037 reset asserted 2 cycles into DWELL -> busy=0 and rows=INIT immediately; req1 after release -> ack1 on the first edge.
